// File: rtl/vsub16_seq.sv
// vsub16_seq: multi-cycle signed vector subtractor, LPC lanes per clock, start/busy/done handshake
module vsub16_seq #(
    parameter int LANES = 16,
    parameter int W     = 16,
    parameter int LPC   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LANES*W-1:0] A,
    input  logic [LANES*W-1:0] B,
    output logic [LANES*W-1:0] DiffV,
    output logic               V,
    output logic [LANES-1:0]   OvMask,
    output logic               busy,
    output logic               done
);
    localparam int N  = LANES / LPC;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [LANES*W-1:0] a_q, b_q;
    logic [CW-1:0]      cnt;
    logic [LPC*W-1:0]   d_s;
    logic [LPC-1:0]     ov_s;
    logic               last;

    assign last = cnt == CW'(N - 1);

    for (genvar g = 0; g < LPC; g++) begin : g_lane
        logic [W-1:0] a_l, b_l, d_l;
        assign a_l = a_q[(int'(cnt) * LPC + g) * W +: W];
        assign b_l = b_q[(int'(cnt) * LPC + g) * W +: W];
        assign d_l = a_l + ~b_l + W'(1);
        assign d_s[g*W +: W] = d_l;
        assign ov_s[g] = (a_l[W-1] != b_l[W-1]) && (d_l[W-1] != a_l[W-1]);
    end

    // next state: accept in IDLE, sweep N slices in RUN, one DONE cycle
    always_comb begin
        state_nx = state == IDLE ? (start ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) : IDLE;
    end

    // state, operand capture, slice write-back and handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            cnt    <= '0;
            DiffV  <= '0;
            V      <= 1'b0;
            OvMask <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    a_q    <= A;
                    b_q    <= B;
                    V      <= 1'b0;
                    OvMask <= '0;
                    cnt    <= '0;
                    busy   <= 1'b1;
                end
                RUN: begin
                    DiffV[int'(cnt) * LPC * W +: LPC * W] <= d_s;
                    OvMask[int'(cnt) * LPC +: LPC]        <= ov_s;
                    V    <= V | (|ov_s);
                    cnt  <= cnt + CW'(1);
                    done <= last;
                end
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vsub16_seq.sv
// tb_vsub16_seq: self-checking bench for vsub16_seq against a lane-arithmetic reference model
module tb_vsub16_seq;
    localparam int LANES = 16, W = 16, LPC = 4, VW = LANES * W;

    logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [VW-1:0]    A = '0, B = '0, DiffV;
    logic [LANES-1:0] OvMask;
    logic             V, busy, done;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    vsub16_seq #(.LANES(LANES), .W(W), .LPC(LPC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .DiffV(DiffV), .V(V), .OvMask(OvMask), .busy(busy), .done(done)
    );

    function automatic void model(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                  output logic [VW-1:0] d, output logic [LANES-1:0] m);
        for (int i = 0; i < LANES; i++) begin
            int x;
            x = int'($signed(a[i*W +: W])) - int'($signed(b[i*W +: W]));
            d[i*W +: W] = x[W-1:0];
            m[i] = (x > (1 << (W - 1)) - 1) || (x < -(1 << (W - 1)));
        end
    endfunction

    function automatic logic [VW-1:0] rep(input logic [W-1:0] x);
        return {LANES{x}};
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [VW-1:0] a, input logic [VW-1:0] b, output int cyc);
        A = a; B = b; start = 1'b1;
        cycle();
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            cycle();
            cyc++;
        end
    endtask

    task automatic test_reset();
        logic [VW-1:0] a, b, ed;
        logic [LANES-1:0] em;
        int cyc, nd;
        #12;
        tests++; if ({DiffV, V, OvMask, busy, done} !== '0) begin fails++; $display("FAIL reset_init: got DiffV=%h V=%b OvMask=%h busy=%b done=%b, want all 0", DiffV, V, OvMask, busy, done); end
        @(negedge clk) rst_n = 1'b1;
        cycle();
        A = rep(16'h4321); B = rep(16'h1111); start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        #2 rst_n = 1'b0;
        #1;
        tests++; if (DiffV !== '0) begin fails++; $display("FAIL reset_mid_diff: got %h want 0", DiffV); end
        tests++; if (V !== 1'b0 || OvMask !== '0) begin fails++; $display("FAIL reset_mid_ov: got V=%b OvMask=%h want 0", V, OvMask); end
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_mid_hs: got busy=%b done=%b want 0", busy, done); end
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (done !== 1'b0 || busy !== 1'b0) nd++;
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (done !== 1'b0 || busy !== 1'b0) nd++;
        end
        tests++; if (nd != 0) begin fails++; $display("FAIL reset_no_done: got %0d busy/done samples after abort, want 0", nd); end
        a = rnd_vec(); b = rnd_vec();
        model(a, b, ed, em);
        run(a, b, cyc);
        tests++; if (cyc != 4) begin fails++; $display("FAIL reset_latency: got %0d want 4", cyc); end
        tests++; if (DiffV !== ed || OvMask !== em) begin fails++; $display("FAIL reset_result: got %h/%h want %h/%h", DiffV, OvMask, ed, em); end
    endtask

    task automatic test_basic();
        int nb, nd;
        A = rep(16'h0003); B = rep(16'h0005); start = 1'b1;
        cycle();
        start = 1'b0;
        nb = 0; nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy === 1'b1) nb++;
            if (done === 1'b1) begin
                nd++;
                tests++; if (DiffV !== rep(16'hFFFE)) begin fails++; $display("FAIL basic_diff: got %h want %h", DiffV, rep(16'hFFFE)); end
                tests++; if (V !== 1'b0 || OvMask !== 16'h0000) begin fails++; $display("FAIL basic_ov: got V=%b OvMask=%h want 0/0000", V, OvMask); end
            end
            cycle();
        end
        tests++; if (nd != 1) begin fails++; $display("FAIL basic_done_pulses: got %0d want 1", nd); end
        tests++; if (nb != 5) begin fails++; $display("FAIL basic_busy_cycles: got %0d want 5", nb); end
    endtask

    task automatic test_ov_neg();
        logic [VW-1:0] a, b;
        int cyc;
        a = '0; b = '0;
        a[15:0] = 16'h8000; b[15:0] = 16'h0001;
        run(a, b, cyc);
        tests++; if (cyc != 4) begin fails++; $display("FAIL ovneg_latency: got %0d want 4", cyc); end
        tests++; if (DiffV[15:0] !== 16'h7FFF || DiffV[VW-1:16] !== '0) begin fails++; $display("FAIL ovneg_diff: got %h want lane0=7fff rest 0", DiffV); end
        tests++; if (OvMask !== 16'h0001 || V !== 1'b1) begin fails++; $display("FAIL ovneg_flags: got OvMask=%h V=%b want 0001/1", OvMask, V); end
    endtask

    task automatic test_ov_pos();
        logic [VW-1:0] a, b;
        int early;
        a = '0; b = '0;
        a[VW-1 -: W] = 16'h7FFF; b[VW-1 -: W] = 16'hFFFF;
        A = a; B = b; start = 1'b1;
        cycle();
        start = 1'b0;
        early = 0;
        for (int i = 0; i < 4; i++) begin
            if (V !== 1'b0) early++;
            cycle();
        end
        tests++; if (early != 0) begin fails++; $display("FAIL ovpos_v_early: got %0d samples with V=1 before last slice, want 0", early); end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL ovpos_done: got %b want 1", done); end
        tests++; if (DiffV[VW-1 -: W] !== 16'h8000 || OvMask !== 16'h8000 || V !== 1'b1) begin fails++; $display("FAIL ovpos_result: got lane15=%h OvMask=%h V=%b want 8000/8000/1", DiffV[VW-1 -: W], OvMask, V); end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] a1, b1, a2, b2, e1, e2;
        logic [LANES-1:0] m1, m2;
        int cyc, gap, bsy;
        a1 = rnd_vec(); b1 = rnd_vec();
        a1[15:0] = 16'h8000; b1[15:0] = 16'h0001;
        a2 = '0; b2 = '0;
        for (int i = 0; i < LANES; i++) begin
            a2[i*W +: W] = W'($urandom_range(255));
            b2[i*W +: W] = W'($urandom_range(255));
        end
        model(a1, b1, e1, m1);
        model(a2, b2, e2, m2);
        A = a1; B = b1; start = 1'b1;
        cycle();
        A = a2; B = b2;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin cycle(); cyc++; end
        tests++; if (cyc != 4) begin fails++; $display("FAIL b2b_latency1: got %0d want 4", cyc); end
        tests++; if (DiffV !== e1 || OvMask !== m1 || V !== 1'b1) begin fails++; $display("FAIL b2b_result1: got %h/%h/%b want %h/%h/1", DiffV, OvMask, V, e1, m1); end
        gap = 0; bsy = 0;
        do begin
            cycle();
            gap++;
            if (gap == 1 && busy !== 1'b0) bsy++;
        end while (done !== 1'b1 && gap < 20);
        start = 1'b0;
        tests++; if (bsy != 0) begin fails++; $display("FAIL b2b_idle_busy: got busy=1 in idle cycle, want 0"); end
        tests++; if (gap != 6) begin fails++; $display("FAIL b2b_spacing: got %0d want 6", gap); end
        tests++; if (DiffV !== e2 || OvMask !== m2 || V !== 1'b0) begin fails++; $display("FAIL b2b_result2: got %h/%h/%b want %h/%h/0", DiffV, OvMask, V, e2, m2); end
        cycle();
        cycle();
    endtask

    task automatic test_isolation();
        int cyc;
        A = rep(16'h1234); B = rep(16'h0234); start = 1'b1;
        cycle();
        start = 1'b0;
        A = rnd_vec(); B = rnd_vec();
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin cycle(); cyc++; end
        tests++; if (cyc != 4) begin fails++; $display("FAIL iso_latency: got %0d want 4", cyc); end
        tests++; if (DiffV !== rep(16'h1000) || OvMask !== '0 || V !== 1'b0) begin fails++; $display("FAIL iso_result: got %h/%h/%b want %h/0/0", DiffV, OvMask, V, rep(16'h1000)); end
    endtask

    task automatic test_random();
        logic [VW-1:0] a, b, ed;
        logic [LANES-1:0] em;
        int cyc;
        for (int n = 0; n < 10; n++) begin
            a = rnd_vec(); b = rnd_vec();
            model(a, b, ed, em);
            run(a, b, cyc);
            tests++; if (cyc != 4) begin fails++; $display("FAIL rand_latency[%0d]: got %0d want 4", n, cyc); end
            tests++; if (DiffV !== ed) begin fails++; $display("FAIL rand_diff[%0d]: got %h want %h", n, DiffV, ed); end
            tests++; if (OvMask !== em || V !== (|em)) begin fails++; $display("FAIL rand_ov[%0d]: got %h/%b want %h/%b", n, OvMask, V, em, |em); end
            cycle();
        end
    endtask

    initial begin
        test_reset();
        cycle();
        cycle();
        test_basic();
        test_ov_neg();
        cycle();
        cycle();
        test_ov_pos();
        cycle();
        cycle();
        test_back_to_back();
        test_isolation();
        cycle();
        cycle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vsub16_seq.md
Name: vsub16_seq

Overview:
- Multi-cycle 16-lane x 16-bit signed vector subtractor, DiffV = A - B per lane, with a signed-overflow summary flag and a per-lane overflow mask.
- Complements the single-cycle vector adder in the vector ALU.
- Processes LPC lanes per clock on a shared subtractor slice, so the area is a fraction of a fully parallel unit.
- Uses a registered start/busy/done handshake toward the vector execute controller.

Parameters:
- LANES, 16, number of vector lanes.
- W, 16, lane width in bits; lane i occupies bits [W*i+W-1 : W*i].
- LPC, 4, lanes processed per cycle. LANES must be an exact multiple of LPC; N = LANES/LPC compute cycles (default 4).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- A  in  LANES*W  minuend vector; sampled on the accepting edge only.
- B  in  LANES*W  subtrahend vector; sampled on the accepting edge only.
- DiffV  out  LANES*W  registered per-lane A-B, two's complement, wraps modulo 2^W.
- V  out  1  OR of all per-lane signed overflows of the current/last operation.
- OvMask  out  LANES  bit i = signed overflow in lane i.
- busy  out  1  high from acceptance through the done cycle.
- done  out  1  single-cycle completion pulse.

Behaviour:
- Reset: async on rst_n=0. State=IDLE; DiffV, V, OvMask, busy, done, internal operand registers and lane counter all 0. Reset mid-operation aborts; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at the rising edge:
  - capture A and B into internal registers;
  - clear V and OvMask;
  - set lane counter to 0, busy=1, go to RUN.
  - DiffV is not cleared; it keeps the prior result until overwritten slice by slice.
- RUN: each edge computes lanes [cnt*LPC .. cnt*LPC+LPC-1] from the captured operands.
  - Write those DiffV lanes and set the matching OvMask bits.
  - V |= OR of the new overflow bits.
  - cnt increments; on the edge where cnt=N-1, go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle; the next edge goes to IDLE with done=0 and busy=0.
- Timing: start accepted at edge k gives done=1 in the cycle after edge k+N (default: 4 cycles after the accepting edge). Repeat rate is one operation per N+2 cycles when start is held high.
- start is ignored while busy=1, including in DONE. No queuing; a held start is accepted on the first IDLE edge.
- A and B may change freely after acceptance without affecting the result.
- Lane overflow: ov_i = (a_msb != b_msb) && (d_msb != a_msb), where d = a - b as W-bit.
- Arithmetic per lane: d = a + ~b + 1, truncated to W bits; no carry between lanes.
- Output validity: DiffV, V and OvMask are valid when done=1 and stay stable until the next accepted start. During RUN they are partial: V and OvMask accumulate, and DiffV mixes new and old lanes.
- done, busy, V and OvMask are all driven from registers; no combinational path from start to done.

Test Plan:
- Reset: assert rst_n=0 mid-RUN (cnt=2) -> all outputs 0, state IDLE, no done pulse. Release reset, pulse start -> done exactly 4 cycles after the accepting edge.
- Basic subtract: all lanes A=0x0003, B=0x0005 -> every DiffV lane 0xFFFE; V=0; OvMask=0x0000; done high one cycle; busy high 5 cycles.
- Overflow, negative: lane 0 A=0x8000, B=0x0001; others 0 -> DiffV lane0=0x7FFF, OvMask=0x0001, V=1.
- Overflow, positive in last slice: lane 15 A=0x7FFF, B=0xFFFF -> lane15=0x8000, OvMask=0x8000, V=1. Check that V stays 0 until the final RUN edge.
- Busy/ignore: hold start high with new A/B during RUN -> no effect on the result. Second operation accepted on the first IDLE edge; done pulses spaced 6 cycles apart. V from operation 1 (=1) is cleared at acceptance of operation 2 (no overflow) -> V=0 at its done.
- Operand isolation: change A and B the cycle after acceptance -> DiffV reflects the captured values, e.g. A=0x1234, B=0x0234 gives 0x1000 in all lanes.
